// File: rtl/oh_deser_pkg.sv
// Shared helpers for the oh_deser slice: counter-width function.
package oh_deser_pkg;

    // Ceiling log2 with a floor of 1, so a single-state counter still has a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/oh_deser_if.sv
// Serial-in / parallel-out valid/ready bus bundle for oh_deser.
interface oh_deser_if #(
    parameter int unsigned PW = 32,
    parameter int unsigned SW = 1
);
    logic          din_valid;
    logic [SW-1:0] din;
    logic          din_ready;
    logic          dout_valid;
    logic [PW-1:0] dout;
    logic          dout_ready;

    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout
    );

    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout
    );
endinterface

// File: rtl/oh_deser_shift_in.sv
// SW-wide shift-in register, PW deep. Beat order follows OH_DESER_MSBFIRST_EN
// (defined: first beat ends in the MSBs; undefined: first beat ends in the LSBs).
module oh_shift_in
    import oh_deser_pkg::*;
#(
    parameter int unsigned PW = 32,
    parameter int unsigned SW = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic          load,
    input  logic [SW-1:0] din,
    output logic [PW-1:0] word_next_c
);

    logic [PW-1:0] shift_q;

    // Value the register takes on load; after NB loads it is a complete word.
    always_comb begin
        word_next_c = '0;
`ifdef OH_DESER_MSBFIRST_EN
        word_next_c = (shift_q << SW) | PW'(din);
`else
        word_next_c = (shift_q >> SW) | (PW'(din) << (PW - SW));
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shift_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= word_next_c;
        end
    end

endmodule

// File: rtl/oh_deser.sv
// Serial-to-parallel deserializer: SW-bit beats in, PW-bit words out, valid/ready
// on both sides. Define OH_DESER_MSBFIRST_EN for network (MSB-first) beat order.
module oh_deser
    import oh_deser_pkg::*;
#(
    parameter int unsigned PW = 32,
    parameter int unsigned SW = 1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       clear,
    oh_deser_if.slave  io,
    output logic       busy
);

    localparam int unsigned NB = PW / SW;
    localparam int unsigned CW = clog2(NB);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          dout_valid_q;
    logic          dout_valid_d;
    logic [PW-1:0] dout_q;
    logic [PW-1:0] dout_d;
    logic [PW-1:0] word_next_c;
    logic          last_c;
    logic          accept_c;
    logic          retire_c;
    logic          din_ready_c;

    assign last_c      = (count_q == CW'(NB - 1));
    // Only the completing beat needs the output register free.
    assign din_ready_c = ~(last_c & dout_valid_q & ~io.dout_ready);
    assign accept_c    = io.din_valid & din_ready_c & ~clear;
    assign retire_c    = dout_valid_q & io.dout_ready;

    oh_shift_in #(
        .PW (PW),
        .SW (SW)
    ) u_shift_in (
        .clk         (clk),
        .nreset      (nreset),
        .clear       (clear),
        .load        (accept_c),
        .din         (io.din),
        .word_next_c (word_next_c)
    );

    // Next-state: beat counter and output register; clear beats every handshake.
    always_comb begin
        count_d      = count_q;
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        if (clear) begin
            count_d      = '0;
            dout_valid_d = 1'b0;
            dout_d       = '0;
        end else begin
            if (accept_c) begin
                count_d = last_c ? '0 : count_q + CW'(1);
            end
            if (retire_c) begin
                dout_valid_d = 1'b0;
            end
            if (accept_c && last_c) begin
                dout_valid_d = 1'b1;
                dout_d       = word_next_c;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign io.din_ready  = din_ready_c;
    assign io.dout_valid = dout_valid_q;
    assign io.dout       = dout_q;
    assign busy          = (count_q != '0);

endmodule

// File: tb/tb_oh_deser.sv
// Scoreboard bench for oh_deser (PW=8, SW=2) plus a PW=SW=8 register-slice instance.
module tb_oh_deser;

    localparam int unsigned PW = 8;
    localparam int unsigned SW = 2;
    localparam int unsigned NB = PW / SW;
`ifdef OH_DESER_MSBFIRST_EN
    localparam logic [PW-1:0] EXP_WORD2 = 8'h6C;
`else
    localparam logic [PW-1:0] EXP_WORD2 = 8'h39;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic clear = 1'b0;
    logic busy;
    logic clear8 = 1'b0;
    logic busy8;

    always #5 clk = ~clk;

    oh_deser_if #(.PW(PW), .SW(SW)) io ();
    oh_deser_if #(.PW(8), .SW(8)) io8 ();

    oh_deser #(.PW(PW), .SW(SW)) u_dut (
        .clk    (clk),
        .nreset (nreset),
        .clear  (clear),
        .io     (io.slave),
        .busy   (busy)
    );

    oh_deser #(.PW(8), .SW(8)) u_dut8 (
        .clk    (clk),
        .nreset (nreset),
        .clear  (clear8),
        .io     (io8.slave),
        .busy   (busy8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beats assembled by position arithmetic, one-deep output slot.
    logic [PW-1:0] exp_q[$];
    int unsigned   beats = 0;
    int unsigned   occ = 0;
    logic [PW-1:0] part = '0;

    always @(negedge clk) begin : model
        logic exp_rdy;
        if (!nreset || clear) begin
            beats = 0;
            occ   = 0;
            part  = '0;
            exp_q.delete();
        end else begin
            exp_rdy = !(beats == NB - 1 && occ != 0 && !io.dout_ready);
            check("din_ready", 32'(io.din_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(beats != 0));
            if (occ != 0 && io.dout_ready) occ--;
            if (io.din_valid && exp_rdy) begin
`ifdef OH_DESER_MSBFIRST_EN
                part = part | (PW'(io.din) << (PW - SW * (beats + 1)));
`else
                part = part | (PW'(io.din) << (SW * beats));
`endif
                beats++;
                if (beats == NB) begin
                    exp_q.push_back(part);
                    occ++;
                    beats = 0;
                    part  = '0;
                end
            end
        end
    end

    // Monitor: pops on every output handshake; checks hold/stability under backpressure.
    logic          hold = 1'b0;
    logic [PW-1:0] hold_d = '0;

    always @(negedge clk) begin : monitor
        logic [PW-1:0] e;
        if (!nreset || clear) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("dout_valid_hold", 32'(io.dout_valid), 32'd1);
                check("dout_stable", 32'(io.dout), 32'(hold_d));
            end
            if (io.dout_valid && io.dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word_count", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout_word", 32'(io.dout), 32'(e));
                end
            end
            hold   = io.dout_valid && !io.dout_ready;
            hold_d = io.dout;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait (bounded) for its handshake; returns stall cycles.
    task automatic beat(input logic [SW-1:0] d, output int unsigned waited);
        io.din_valid = 1'b1;
        io.din       = d;
        waited       = 0;
        @(negedge clk);
        while (!io.din_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 100) check("beat_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int unsigned   w;
        logic [31:0]   r;
        logic [7:0]    last8;
        logic [SW-1:0] seq2 [4];
        seq2[0] = 2'b01; seq2[1] = 2'b10; seq2[2] = 2'b11; seq2[3] = 2'b00;

        io.din_valid   = 1'b0;
        io.din         = '0;
        io.dout_ready  = 1'b0;
        io8.din_valid  = 1'b0;
        io8.din        = '0;
        io8.dout_ready = 1'b0;
        #22 nreset = 1'b1;
        cyc();
        check("reset_din_ready", 32'(io.din_ready), 32'd1);
        check("reset_dout_valid", 32'(io.dout_valid), 32'd0);

        // Async reset with a held word and a partial word in flight.
        for (int i = 0; i < 6; i++) beat(2'($urandom), w);
        io.din_valid = 1'b0;
        check("pre_reset_valid", 32'(io.dout_valid), 32'd1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_valid", 32'(io.dout_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_dout", 32'(io.dout), 32'd0);
        cyc();
        #3 nreset = 1'b1;
        cyc();
        check("post_rst_din_ready", 32'(io.din_ready), 32'd1);

        // Fixed pattern, word visible one cycle after the last beat.
        io.dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(seq2[i], w);
        check("pattern_valid", 32'(io.dout_valid), 32'd1);
        check("pattern_word", 32'(io.dout), 32'(EXP_WORD2));
        io.din_valid = 1'b0;
        cyc();

        // Back-to-back words with the sink always ready: no beat ever waits.
        for (int i = 0; i < 3 * NB; i++) begin
            beat(2'($urandom), w);
            check("b2b_wait", 32'(w), 32'd0);
        end
        io.din_valid = 1'b0;
        cyc();
        cyc();

        // Backpressure: three beats pass, the completing beat stalls.
        io.dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(2'($urandom), w);
        for (int i = 0; i < 3; i++) begin
            beat(2'($urandom), w);
            check("stall_early_wait", 32'(w), 32'd0);
        end
        io.din_valid = 1'b1;
        io.din       = 2'($urandom);
        check("stall_last_ready", 32'(io.din_ready), 32'd0);
        cyc();
        check("stall_last_ready2", 32'(io.din_ready), 32'd0);
        io.dout_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(io.din_ready), 32'd1);
        @(posedge clk);
        #1;
        check("swap_no_bubble", 32'(io.dout_valid), 32'd1);
        io.din_valid = 1'b0;
        cyc();
        cyc();

        // clear drops a held word and a partial word.
        io.dout_ready = 1'b0;
        for (int i = 0; i < 4 + 3; i++) beat(2'($urandom), w);
        io.din_valid = 1'b0;
        check("pre_clear_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_valid", 32'(io.dout_valid), 32'd0);
        io.dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(2'($urandom), w);
        io.din_valid = 1'b0;
        cyc();
        cyc();

        // Random traffic with random backpressure and occasional clear.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            if (r[15:10] == 6'd0) begin
                clear         = 1'b1;
                io.din_valid  = 1'b0;
                io.dout_ready = 1'b0;
            end else begin
                clear         = 1'b0;
                io.din_valid  = r[1] | r[2];
                io.din        = r[5:4];
                io.dout_ready = (r[9:8] != 2'd0);
            end
            cyc();
        end
        clear         = 1'b0;
        io.din_valid  = 1'b0;
        io.dout_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // PW==SW: one-deep register slice, ready follows dout_ready while full.
        io8.din_valid  = 1'b1;
        io8.din        = 8'hA5;
        io8.dout_ready = 1'b1;
        cyc();
        check("slice_valid", 32'(io8.dout_valid), 32'd1);
        check("slice_word", 32'(io8.dout), 32'hA5);
        check("slice_busy", 32'(busy8), 32'd0);
        last8 = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            io8.dout_ready = i[0];
            io8.din        = 8'h10 + 8'(i);
            #1;
            check("slice_ready", 32'(io8.din_ready), 32'(i[0]));
            check("slice_hold", 32'(io8.dout), 32'(last8));
            @(posedge clk);
            #1;
            if (i[0]) last8 = 8'h10 + 8'(i);
        end
        check("slice_last", 32'(io8.dout), 32'(last8));
        io8.din_valid  = 1'b0;
        io8.dout_ready = 1'b1;
        cyc();
        check("slice_empty", 32'(io8.dout_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
